// File: rtl/ahb_cmd_master.sv
// AHB-Lite initiator: turns a valid/ready command stream into pipelined NONSEQ transfers, one response each.
// Optional data-phase timeout is compiled in with `define AHB_CMD_MASTER_TIMEOUT_EN.
module ahb_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [2:0]  cmd_size,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic        rsp_write,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY
);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // Handshake: a command transfers on a rising HCLK edge with cmd_valid & cmd_ready;
    // cmd_ready is combinational and never depends on cmd_valid. rsp_valid is a one-cycle
    // pulse with no backpressure, so the consumer must take it when it appears.

    // HADDR/HWRITE/HSIZE double as the address-phase slot; ap_wdata waits there for the data phase.
    logic        ap_valid;
    logic [31:0] ap_wdata;
    logic        dp_valid;
    logic        dp_write;
    logic        accept;
    logic        advance;
    logic        timeout_hit;
    logic [2:0]  size_clamped;
    logic [31:0] addr_aligned;

    assign cmd_ready = ~ap_valid | HREADY;
    assign accept    = cmd_valid & cmd_ready;
    assign busy      = ap_valid | dp_valid;
    assign HTRANS    = ap_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign advance   = HREADY | timeout_hit;

    always_comb begin
        size_clamped = (cmd_size > 3'd2) ? 3'd2 : cmd_size;
        addr_aligned = cmd_addr;
        if (size_clamped == 3'd1) begin
            addr_aligned[0] = 1'b0;
        end else if (size_clamped == 3'd2) begin
            addr_aligned[1:0] = 2'b00;
        end
    end

`ifdef AHB_CMD_MASTER_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    logic [TO_W-1:0] to_cnt;

    // The edge that would make the count reach TIMEOUT_CYCLES retires the stuck transfer.
    assign timeout_hit = dp_valid & ~HREADY & (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge HCLK) begin
        if (!HRESETn || HREADY || timeout_hit) begin
            to_cnt <= '0;
        end else if (dp_valid) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    // Without the timeout a stalled slave stalls the master indefinitely.
    assign timeout_hit = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            ap_valid  <= 1'b0;
            ap_wdata  <= '0;
            dp_valid  <= 1'b0;
            dp_write  <= 1'b0;
            HADDR     <= '0;
            HWRITE    <= 1'b0;
            HSIZE     <= '0;
            HWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            if (dp_valid && advance) begin
                rsp_valid <= 1'b1;
                rsp_write <= dp_write;
                rsp_err   <= timeout_hit;
                rsp_rdata <= (dp_write || timeout_hit) ? 32'h0 : HRDATA;
            end
            // Address and data phases complete together, so the pipeline shifts as one.
            if (advance) begin
                dp_valid <= ap_valid;
                dp_write <= HWRITE;
                if (ap_valid && HWRITE) begin
                    HWDATA <= ap_wdata;
                end
            end
            if (accept) begin
                ap_valid <= 1'b1;
                HADDR    <= addr_aligned;
                HWRITE   <= cmd_write;
                HSIZE    <= size_clamped;
                ap_wdata <= cmd_wdata;
            end else if (ap_valid && advance) begin
                ap_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ahb_cmd_master.sv
// Directed bench for ahb_cmd_master: bench-driven slave, response and write-data scoreboards.
`timescale 1ns/1ps
module tb_ahb_cmd_master;
    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;

    ahb_cmd_master #(.TIMEOUT_CYCLES(8)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY)
    );

    // ---------------- clock / reset ----------------
    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [33:0] exp_q[$];   // {err, write, rdata}
    logic [31:0] wd_q[$];    // write data in command order
    logic [33:0] exp_head;
    logic        wd_due = 1'b0;
    int nonseq_cnt = 0;
    int sample_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [33:0] wr_rsp();
        return {1'b0, 1'b1, 32'h0};
    endfunction

    function automatic logic [33:0] rd_rsp(input logic [31:0] d);
        return {1'b0, 1'b0, d};
    endfunction

    always @(negedge HCLK) begin
        if (HRESETn === 1'b1 && rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got err=%0b write=%0b rdata=0x%0h, no response expected",
                         rsp_err, rsp_write, rsp_rdata);
            end else begin
                exp_head = exp_q.pop_front();
                check("rsp_err_write_rdata", 64'({rsp_err, rsp_write, rsp_rdata}), 64'(exp_head));
            end
        end
    end

    // A write whose address phase completes at an edge shows its data during the next cycle.
    always @(posedge HCLK) begin
        wd_due <= (HRESETn === 1'b1) && (HTRANS == 2'b10) && (HREADY === 1'b1) && (HWRITE === 1'b1);
    end

    always @(negedge HCLK) begin
        if (wd_due) begin
            if (wd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL hwdata_unexpected: got write data phase 0x%0h, none expected", HWDATA);
            end else begin
                check("hwdata", 64'(HWDATA), 64'(wd_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic w, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] d, input logic [33:0] exp_rsp);
        bit accepted;
        accepted  = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_size  = sz;
        cmd_addr  = a;
        cmd_wdata = d;
        exp_q.push_back(exp_rsp);
        if (w) wd_q.push_back(d);
        for (int i = 0; i < 40 && !accepted; i++) begin
            @(negedge HCLK);
            sample_cnt++;
            if (HTRANS == 2'b10) nonseq_cnt++;
            accepted = cmd_ready;
            @(posedge HCLK);
            #1;
        end
        cmd_valid = 1'b0;
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got cmd_ready=0 for 40 cycles, expected acceptance");
        end
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 60 && !idle; i++) begin
            @(negedge HCLK);
            idle = !busy;
            @(posedge HCLK);
            #1;
        end
        if (!idle) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=1 for 60 cycles, expected 0");
        end
    endtask

    task automatic cycle();
        @(posedge HCLK);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        HRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_size  = 3'd0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        HREADY    = 1'b1;
        HRDATA    = 32'h0;
        repeat (3) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;

        // reset state
        @(negedge HCLK);
        check("rst_htrans", 64'(HTRANS), 64'(2'b00));
        check("rst_haddr", 64'(HADDR), 64'(32'h0));
        check("rst_hwrite_hsize", 64'({HWRITE, HSIZE}), 64'(4'h0));
        check("rst_hwdata", 64'(HWDATA), 64'(32'h0));
        check("rst_rsp", 64'({rsp_valid, rsp_write, rsp_err, rsp_rdata}), 64'(35'h0));
        check("rst_busy", 64'(busy), 64'(1'b0));
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1'b1));
        cycle();

        // single word write then read
        HRDATA = 32'h78;
        issue(1'b1, 3'd2, 32'h4, 32'h12345678, wr_rsp());
        @(negedge HCLK);
        check("t1_wr_htrans", 64'(HTRANS), 64'(2'b10));
        check("t1_wr_haddr", 64'(HADDR), 64'(32'h4));
        check("t1_wr_hwrite_hsize", 64'({HWRITE, HSIZE}), 64'({1'b1, 3'd2}));
        cycle();
        issue(1'b0, 3'd2, 32'h4, 32'h0, rd_rsp(32'h78));
        @(negedge HCLK);
        check("t1_rd_htrans", 64'(HTRANS), 64'(2'b10));
        check("t1_rd_hwrite", 64'(HWRITE), 64'(1'b0));
        cycle();
        wait_idle();

        // back-to-back writes
        nonseq_cnt = 0;
        sample_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            issue(1'b1, 3'd2, 32'h4, 32'(20 + i), wr_rsp());
        end
        @(negedge HCLK);
        check("b2b_last_nonseq", 64'(HTRANS), 64'(2'b10));
        check("b2b_nonseq_run", 64'(nonseq_cnt), 64'(19));
        check("b2b_accept_cycles", 64'(sample_cnt), 64'(20));
        check("b2b_busy_ap", 64'(busy), 64'(1'b1));
        cycle();
        @(negedge HCLK);
        check("b2b_busy_dp", 64'(busy), 64'(1'b1));
        check("b2b_idle_after", 64'(HTRANS), 64'(2'b00));
        cycle();
        @(negedge HCLK);
        check("b2b_busy_fall", 64'(busy), 64'(1'b0));
        cycle();

        // wait states with a queued write
        HRDATA = 32'h2;
        issue(1'b0, 3'd2, 32'h8, 32'h0, rd_rsp(32'h2));
        issue(1'b1, 3'd2, 32'hC, 32'hC, wr_rsp());
        HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            check("ws_haddr", 64'(HADDR), 64'(32'hC));
            check("ws_htrans", 64'(HTRANS), 64'(2'b10));
            check("ws_hwrite", 64'(HWRITE), 64'(1'b1));
            check("ws_cmd_ready", 64'(cmd_ready), 64'(1'b0));
            check("ws_rsp_valid", 64'(rsp_valid), 64'(1'b0));
            cycle();
        end
        HREADY = 1'b1;
        wait_idle();

        // size clamp and address alignment
        issue(1'b1, 3'd1, 32'h7, 32'h0000AAAA, wr_rsp());
        @(negedge HCLK);
        check("half_haddr", 64'(HADDR), 64'(32'h6));
        check("half_hsize", 64'(HSIZE), 64'(3'd1));
        cycle();
        wait_idle();
        issue(1'b1, 3'd5, 32'hB, 32'h00000055, wr_rsp());
        @(negedge HCLK);
        check("clamp_haddr", 64'(HADDR), 64'(32'h8));
        check("clamp_hsize", 64'(HSIZE), 64'(3'd2));
        cycle();
        wait_idle();

        // reset with both slots occupied
        issue(1'b0, 3'd2, 32'h10, 32'h0, rd_rsp(32'h2));
        issue(1'b1, 3'd2, 32'h14, 32'h99, wr_rsp());
        HREADY = 1'b0;
        @(negedge HCLK);
        check("mid_busy_before", 64'(busy), 64'(1'b1));
        cycle();
        HRESETn = 1'b0;
        exp_q.delete();
        wd_q.delete();
        cycle();
        HRESETn = 1'b1;
        HREADY  = 1'b1;
        @(negedge HCLK);
        check("mid_htrans", 64'(HTRANS), 64'(2'b00));
        check("mid_busy", 64'(busy), 64'(1'b0));
        check("mid_rsp_valid", 64'(rsp_valid), 64'(1'b0));
        cycle();
        repeat (3) cycle();
        issue(1'b0, 3'd2, 32'h18, 32'h0, rd_rsp(32'h2));
        wait_idle();

        // stuck slave in a read data phase
        HRDATA = 32'h5A5A;
`ifdef AHB_CMD_MASTER_TIMEOUT_EN
        issue(1'b0, 3'd2, 32'h20, 32'h0, {1'b1, 1'b0, 32'h0});
`else
        issue(1'b0, 3'd2, 32'h20, 32'h0, rd_rsp(32'h5A5A));
`endif
        cycle();
        HREADY = 1'b0;
        repeat (7) cycle();
        @(negedge HCLK);
        check("to_before_limit", 64'(rsp_valid), 64'(1'b0));
        cycle();
        @(negedge HCLK);
`ifdef AHB_CMD_MASTER_TIMEOUT_EN
        check("to_rsp_valid_err", 64'({rsp_valid, rsp_err}), 64'(2'b11));
        check("to_busy", 64'(busy), 64'(1'b0));
`else
        check("to_no_rsp", 64'(rsp_valid), 64'(1'b0));
        repeat (10) cycle();
        @(negedge HCLK);
        check("to_busy_stuck", 64'(busy), 64'(1'b1));
        check("to_rsp_pending", 64'(exp_q.size()), 64'(1));
`endif
        cycle();
        HREADY = 1'b1;
        wait_idle();

        repeat (3) cycle();
        check("drain_rsp_queue", 64'(exp_q.size()), 64'(0));
        check("drain_wdata_queue", 64'(wd_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
